// File: rtl/udi_ext_bridge.sv
// Purpose: buffers committed UDI command words, issues them one at a time to an external peripheral, holds the single response for the UDI.
// Latency: push -> ext_req_valid 2 cycles; response handshake -> rsp_valid 1 cycle; next request 2 cycles after a handshake at the earliest.
// Backpressure: cmd_full stalls the UDI push (pushes while full are dropped, cmd_overflow is sticky); an unread result holds ext_rsp_ready low.
// Optional feature: define UDI_EXT_BRIDGE_TIMEOUT_EN to add the response watchdog and the rsp_err output.
module udi_ext_bridge #(
    parameter int DEPTH       = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       UDI_gclk,
    input  logic                       UDI_greset_n,
    input  logic                       cmd_valid,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic [TAG_W-1:0]           cmd_tag,
    input  logic                       cmd_flush,
    output logic                       cmd_full,
    output logic                       cmd_overflow,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       ext_req_valid,
    output logic [DATA_W-1:0]          ext_req_data,
    output logic [TAG_W-1:0]           ext_req_tag,
    input  logic                       ext_req_ready,
    input  logic                       ext_rsp_valid,
    input  logic [DATA_W-1:0]          ext_rsp_data,
    output logic                       ext_rsp_ready,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    input  logic                       rsp_pop,
    output logic                       busy
`ifdef UDI_EXT_BRIDGE_TIMEOUT_EN
    ,
    output logic                       rsp_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic push;
    logic pop;
    logic rsp_fire;
    logic timeout_fire;

    // A push while full is dropped even if the head leaves this cycle; flush beats any push.
    assign push     = cmd_valid && !cmd_full && !cmd_flush;
    // The head moves into the request registers on the IDLE -> ISSUE edge.
    assign pop      = (state == IDLE) && (count != '0);
    assign rsp_fire = ext_rsp_valid && ext_rsp_ready;

    assign cmd_full      = (count == FULL_CNT);
    assign fifo_count    = count;
    assign ext_req_valid = (state == ISSUE);
    assign ext_rsp_ready = (state == WAIT_RSP) && !rsp_valid;
    assign busy          = (state != IDLE) || (count != '0);

    // Command storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge UDI_gclk) begin
        if (push) begin
            mem_data[wr_ptr] <= cmd_data;
            mem_tag[wr_ptr]  <= cmd_tag;
        end
    end

    // FIFO pointers and occupancy; flush empties the queue but leaves the in-flight request alone.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (cmd_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky record of a dropped push, cleared only by flush or reset.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            cmd_overflow <= 1'b0;
        end else if (cmd_flush) begin
            cmd_overflow <= 1'b0;
        end else if (cmd_valid && cmd_full) begin
            cmd_overflow <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one request outstanding at a time, back to IDLE once a result is captured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (count != '0) state_nxt = ISSUE;
            ISSUE:    if (ext_req_ready) state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_fire || timeout_fire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request registers: loaded from the FIFO head and held stable through ISSUE and WAIT_RSP.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            ext_req_data <= '0;
            ext_req_tag  <= '0;
        end else if (pop) begin
            ext_req_data <= mem_data[rd_ptr];
            ext_req_tag  <= mem_tag[rd_ptr];
        end
    end

`ifdef UDI_EXT_BRIDGE_TIMEOUT_EN
    logic [7:0] wd_cnt;

    // Watchdog: zero outside WAIT_RSP, counts silent WAIT_RSP cycles, saturates at its maximum.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            wd_cnt <= '0;
        end else if (state != WAIT_RSP) begin
            wd_cnt <= '0;
        end else if (!ext_rsp_valid && (wd_cnt != 8'hFF)) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Fires on the silent cycle whose increment brings the count to the limit, if the result slot is free.
    assign timeout_fire = (state == WAIT_RSP) && !ext_rsp_valid && !rsp_valid &&
                          ((int'(wd_cnt) + 1) >= TIMEOUT_CYC);

    // Error flag travels with the timeout result and is consumed by the same pop.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            rsp_err <= 1'b0;
        end else if (rsp_fire) begin
            rsp_err <= 1'b0;
        end else if (timeout_fire) begin
            rsp_err <= 1'b1;
        end else if (rsp_pop) begin
            rsp_err <= 1'b0;
        end
    end
`else
    // Watchdog absent: WAIT_RSP waits for the peripheral indefinitely (TIMEOUT_CYC is never negative).
    assign timeout_fire = (TIMEOUT_CYC < 0);
`endif

    // Result register: captures a response (or timeout marker) with the originating tag; pop frees it.
    always_ff @(posedge UDI_gclk or negedge UDI_greset_n) begin
        if (!UDI_greset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= ext_rsp_data;
            rsp_tag   <= ext_req_tag;
        end else if (timeout_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= DATA_W'(32'hDEAD_BEEF);
            rsp_tag   <= ext_req_tag;
        end else if (rsp_pop) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
